// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared FSM state, op encoding and default widths for dmem_arbiter
package dmem_arb_pkg;
  localparam int DEF_AW = 16;
  localparam int DEF_DW = 16;
  typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_e;
  typedef enum logic {OP_RD, OP_WR} op_e;
endpackage

// File: rtl/dmem_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker, search starts at i_ptr and wraps
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [N-1:0]  i_mask,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic          o_valid,
  output logic [PW-1:0] o_idx
);
  logic [N-1:0] w_elig;
  assign w_elig  = i_req & ~i_mask;
  assign o_valid = |w_elig;
  // Lowest eligible index overall, overridden by lowest eligible at or above the pointer.
  always_comb begin
    o_idx = '0;
    for (int c = N - 1; c >= 0; c--) if (w_elig[c]) o_idx = PW'(c);
    for (int c = N - 1; c >= 0; c--) if (w_elig[c] && c >= int'(i_ptr)) o_idx = PW'(c);
    o_grant = o_valid ? N'(1) << o_idx : '0;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of one data memory among NCORES cores.
// Define DMEM_ARB_LOCK_EN to let a core keep ownership across accesses via req_lock.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NCORES = 4,
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCORES-1:0]    req_rd,
  input  logic [NCORES-1:0]    req_wr,
  input  logic [NCORES*AW-1:0] req_addr,
  input  logic [NCORES*DW-1:0] req_wdata,
  input  logic [NCORES-1:0]    req_lock,
  output logic [NCORES-1:0]    ack,
  output logic [DW-1:0]        rdata,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_dout,
  output logic                 mem_read,
  output logic                 mem_wr,
  input  logic [DW-1:0]        mem_din
);
  localparam int PW = $clog2(NCORES);
  state_e r_state, w_next;
  op_e r_op;
  logic [PW-1:0] r_ptr, r_win, w_idx;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata, r_rdata;
  logic [NCORES-1:0] w_mask, w_grant, w_win_oh;
  logic w_valid, w_take;
  assign w_win_oh = NCORES'(1) << r_win;
  assign w_take   = (r_state == IDLE || r_state == ACK) && w_valid;
`ifdef DMEM_ARB_LOCK_EN
  logic r_locked;
  // While locked the owner is always the last winner, so r_win doubles as the owner id.
  assign w_mask = (r_state == ACK) ? (req_lock[r_win] ? '1 : w_win_oh)
                                   : (r_locked ? ~w_win_oh : '0);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_locked <= 1'b0;
    else if (r_state == ACK) r_locked <= req_lock[r_win];
`else
  logic w_unused_lock;
  assign w_unused_lock = ^req_lock;
  assign w_mask = (r_state == ACK) ? w_win_oh : '0;
`endif
  rr_arbiter #(.N(NCORES)) u_rr (
    .i_req(req_rd | req_wr), .i_mask(w_mask), .i_ptr(r_ptr),
    .o_grant(w_grant), .o_valid(w_valid), .o_idx(w_idx)
  );
  always_comb begin
    w_next   = w_take ? ISSUE : IDLE;
    mem_read = 1'b0;
    mem_wr   = 1'b0;
    ack      = '0;
    if (r_state == ISSUE) begin
      w_next   = ACK;
      mem_read = (r_op == OP_RD);
      mem_wr   = (r_op == OP_WR);
    end
    if (r_state == ACK) ack = w_win_oh;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_win   <= '0;
      r_op    <= OP_RD;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_win   <= w_idx;
        r_ptr   <= (w_idx == PW'(NCORES - 1)) ? '0 : w_idx + 1'b1;
        r_op    <= |(req_wr & w_grant) ? OP_WR : OP_RD;
        r_addr  <= req_addr[w_idx*AW +: AW];
        r_wdata <= req_wdata[w_idx*DW +: DW];
      end
      if (r_state == ACK && r_op == OP_RD) r_rdata <= mem_din;
    end
  assign mem_addr = r_addr;
  assign mem_dout = r_wdata;
  assign rdata    = r_rdata;
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter NCORES, default 4, number of cores sharing one data memory (2..8).
REQ-002 Parameter AW, default 16, data-memory address width.
REQ-003 Parameter DW, default 16, data-memory word width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_rd  input  NCORES  per-core read request (core's MEMREAD).
REQ-007 req_wr  input  NCORES  per-core write request (core's MEMWR).
REQ-008 req_addr  input  NCORES*AW  per-core address, core i in slice [i*AW +: AW].
REQ-009 req_wdata  input  NCORES*DW  per-core write data, same slicing.
REQ-010 req_lock  input  NCORES  per-core bus-lock request (see Configuration).
REQ-011 ack  output  NCORES  one-cycle completion pulse to the served core.
REQ-012 rdata  output  DW  read data, shared by all cores.
REQ-013 mem_addr / mem_dout  output  AW / DW  address and write data to the data memory.
REQ-014 mem_read / mem_wr  output  1 / 1  memory read / write strobes.
REQ-015 mem_din  input  DW  memory read data, valid one cycle after a mem_read cycle.

Function
REQ-016 FSM states: IDLE, ISSUE, ACK.
REQ-017 IDLE: a core is pending when req_rd|req_wr is set; with any pending, pick winner by round-robin, latch its op/addr/wdata, go ISSUE; otherwise stay.
REQ-018 Round-robin: search starts at pointer ptr, ascending with wrap from NCORES-1 to 0; after every grant ptr = winner+1 mod NCORES.
REQ-019 ISSUE: drive latched address/data and assert exactly one of mem_read/mem_wr for exactly one cycle; go ACK.
REQ-020 ACK: pulse ack[winner] for one cycle; for a read, register mem_din into rdata on this edge.
REQ-021 ACK: the current winner is masked from arbitration; if another core is pending, grant it directly (ACK->ISSUE), else go IDLE.
REQ-022 Transaction latency: request seen in IDLE -> ack 2 cycles later; back-to-back throughput one access per 2 cycles.
REQ-023 req_rd and req_wr both set on one core: treated as a write; no read issued.
REQ-024 Cores hold request, address and data stable until ack and drop request the cycle after ack; arbiter never samples a core's inputs outside its grant cycle.
REQ-025 rdata holds its value until the next read ack; writes leave rdata unchanged.
REQ-026 mem_read, mem_wr and ack are never asserted outside ISSUE/ACK; at most one ack bit set per cycle.

Reset
REQ-027 rst assertion forces immediately: state IDLE, ptr 0, ack 0, mem_read 0, mem_wr 0, mem_addr 0, mem_dout 0, rdata 0.
REQ-028 Reset during ISSUE aborts the access (strobe drops asynchronously); no ack is issued for it afterwards.
REQ-029 First arbitration occurs on the first rising edge after rst deasserts.

Configuration
REQ-030 Macro DMEM_ARB_LOCK_EN defined: if req_lock[winner] is high in ACK, ownership is retained; only that core may be granted until it completes an access with req_lock low; while holding, an idle owner keeps the FSM in IDLE and other cores wait.
REQ-031 Macro undefined: req_lock is ignored entirely; no lock state is synthesised.

Structure
REQ-032 Package dmem_arb_pkg holds the FSM state enum, the default AW/DW constants and the op encoding (OP_RD, OP_WR).
REQ-033 Sub-module rr_arbiter: combinational round-robin picker (request vector, mask, ptr -> one-hot grant, valid); dmem_arbiter holds all sequential state.

Verification
REQ-034 Single read: core 1 reads 0x0040 with memory holding 0xBEEF -> mem_read one cycle with addr 0x0040, ack[1] 2 cycles after request, rdata 0xBEEF.
REQ-035 Simultaneous: cores 0..3 all write at ptr 0 -> grants in order 0,1,2,3, acks 2 cycles apart, each mem_dout matching that core's data.
REQ-036 Fairness: core 0 requests continuously and core 2 requests once -> after core 0's grant, core 2 is served next; neither starved.
REQ-037 rd+wr together: core 3 asserts both, addr 0x0010, data 0x1234 -> mem_wr only, memory[0x0010]=0x1234, rdata unchanged.
REQ-038 Reset mid-ISSUE: assert rst during a write strobe -> mem_wr 0 same cycle, no ack, ptr 0 after release.
REQ-039 Lock (DMEM_ARB_LOCK_EN): core 1 read with lock, core 2 pending, then core 1 write without lock -> core 2 served only after core 1's write ack; without the macro, core 2 is served between them.
